// File: rtl/omsp_hmac_arbiter.sv
// Two-client ownership arbiter in front of the shared HMAC engine.
// Round-robin grant, engine scrub between owners, idle watchdog revocation.
module omsp_hmac_arbiter #(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   output logic [1:0]  gnt,
   input  logic        c0_hmac_reset,
   input  logic        c0_start_continue,
   input  logic        c0_data_available,
   input  logic        c0_data_is_long,
   input  logic [15:0] c0_data_in,
   input  logic        c1_hmac_reset,
   input  logic        c1_start_continue,
   input  logic        c1_data_available,
   input  logic        c1_data_is_long,
   input  logic [15:0] c1_data_in,
   input  logic        hmac_busy,
   output logic        hmac_reset,
   output logic        hmac_start_continue,
   output logic        hmac_data_available,
   output logic        hmac_data_is_long,
   output logic [15:0] hmac_data_in,
   output logic [1:0]  c_busy,
   output logic [1:0]  aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCRUB,
      S_OWNED,
      S_DRAIN,
      S_ABORT
   } state_t;

   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] WD_MAX  = '1;

   state_t           r_state;
   state_t           w_next;
   logic             r_owner;
   logic             w_owner_nxt;
   logic             r_last;
   logic             w_last_nxt;
   logic [CNT_W-1:0] r_wd;
   logic [1:0]       r_gnt;
   logic [1:0]       r_aborted;

   logic             w_req_own;
   logic             w_sel_rst;
   logic             w_sel_sc;
   logic             w_sel_dav;
   logic             w_sel_dil;
   logic [15:0]      w_sel_data;
   logic             w_idle;

   // Only the registered owner's controls are ever visible to the engine
   assign w_req_own  = r_owner ? req[1] : req[0];
   assign w_sel_rst  = r_owner ? c1_hmac_reset     : c0_hmac_reset;
   assign w_sel_sc   = r_owner ? c1_start_continue : c0_start_continue;
   assign w_sel_dav  = r_owner ? c1_data_available : c0_data_available;
   assign w_sel_dil  = r_owner ? c1_data_is_long   : c0_data_is_long;
   assign w_sel_data = r_owner ? c1_data_in        : c0_data_in;
   assign w_idle     = !hmac_busy && !w_sel_sc;

   always_comb begin
      w_next      = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      unique case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_next      = S_SCRUB;
               w_owner_nxt = (&req) ? ~r_last : req[1];
            end
         end
         S_SCRUB: begin
            if (!hmac_busy) w_next = S_OWNED;
         end
         S_OWNED: begin
            // A voluntary release takes priority over a coincident timeout
            if (!w_req_own)
               w_next = S_DRAIN;
            else if (w_idle && r_wd == WD_LAST)
               w_next = S_ABORT;
         end
         S_DRAIN: begin
            if (!hmac_busy) begin
               w_next     = S_IDLE;
               w_last_nxt = r_owner;
            end
         end
         S_ABORT: begin
            if (!w_req_own) begin
               w_next     = S_IDLE;
               w_last_nxt = r_owner;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      hmac_reset          = 1'b1;
      hmac_start_continue = 1'b0;
      hmac_data_available = 1'b0;
      hmac_data_is_long   = 1'b0;
      hmac_data_in        = '0;
      c_busy              = 2'b11;
      unique case (r_state)
         S_OWNED: begin
            hmac_reset          = w_sel_rst;
            hmac_start_continue = w_sel_sc;
            hmac_data_available = w_sel_dav;
            hmac_data_is_long   = w_sel_dil;
            hmac_data_in        = w_sel_data;
            c_busy[r_owner]     = hmac_busy;
         end
         S_DRAIN: hmac_reset = 1'b0;
         default: hmac_reset = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_wd      <= '0;
         r_gnt     <= '0;
         r_aborted <= '0;
      end else begin
         r_state   <= w_next;
         r_owner   <= w_owner_nxt;
         r_last    <= w_last_nxt;
         r_gnt     <= (w_next == S_OWNED) ?
                      {w_owner_nxt, ~w_owner_nxt} : 2'b00;
         r_aborted <= (r_state == S_OWNED && w_next == S_ABORT) ?
                      {r_owner, ~r_owner} : 2'b00;
         if (r_state != S_OWNED || !w_idle)
            r_wd <= '0;
         else if (r_wd != WD_MAX)
            r_wd <= r_wd + 1'b1;
      end
   end

   assign gnt     = r_gnt;
   assign aborted = r_aborted;

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// Vector/scoreboard bench for omsp_hmac_arbiter with a short watchdog.
module tb_omsp_hmac_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        c0_hmac_reset, c0_start_continue;
   logic        c0_data_available, c0_data_is_long;
   logic [15:0] c0_data_in;
   logic        c1_hmac_reset, c1_start_continue;
   logic        c1_data_available, c1_data_is_long;
   logic [15:0] c1_data_in;
   logic        hmac_busy;
   logic        hmac_reset, hmac_start_continue;
   logic        hmac_data_available, hmac_data_is_long;
   logic [15:0] hmac_data_in;
   logic [1:0]  c_busy;
   logic [1:0]  aborted;

   always #5 clk = ~clk;

   omsp_hmac_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .req                 (req),
      .gnt                 (gnt),
      .c0_hmac_reset       (c0_hmac_reset),
      .c0_start_continue   (c0_start_continue),
      .c0_data_available   (c0_data_available),
      .c0_data_is_long     (c0_data_is_long),
      .c0_data_in          (c0_data_in),
      .c1_hmac_reset       (c1_hmac_reset),
      .c1_start_continue   (c1_start_continue),
      .c1_data_available   (c1_data_available),
      .c1_data_is_long     (c1_data_is_long),
      .c1_data_in          (c1_data_in),
      .hmac_busy           (hmac_busy),
      .hmac_reset          (hmac_reset),
      .hmac_start_continue (hmac_start_continue),
      .hmac_data_available (hmac_data_available),
      .hmac_data_is_long   (hmac_data_is_long),
      .hmac_data_in        (hmac_data_in),
      .c_busy              (c_busy),
      .aborted             (aborted)
   );

   typedef struct {
      string       nm;
      logic [1:0]  req;
      logic        busy;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        sc0;
      logic        sc1;
      logic [1:0]  e_gnt;
      logic        e_rst;
      logic [15:0] e_data;
      logic        e_sc;
      logic [1:0]  e_cb;
      logic [1:0]  e_ab;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic vec_t mk(
      string nm, logic [1:0] rq, logic bz,
      logic [15:0] d0, logic [15:0] d1, logic s0, logic s1,
      logic [1:0] eg, logic er, logic [15:0] ed, logic es,
      logic [1:0] ec, logic [1:0] ea);
      vec_t v;
      v.nm = nm; v.req = rq; v.busy = bz;
      v.d0 = d0; v.d1 = d1; v.sc0 = s0; v.sc1 = s1;
      v.e_gnt = eg; v.e_rst = er; v.e_data = ed;
      v.e_sc = es; v.e_cb = ec; v.e_ab = ea;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Data bits double as the side controls so they are checked too
   task automatic apply(input vec_t v);
      vec_t e;
      req               = v.req;
      hmac_busy         = v.busy;
      c0_data_in        = v.d0;
      c0_data_available = v.d0[0];
      c0_data_is_long   = v.d0[1];
      c0_hmac_reset     = 1'b0;
      c0_start_continue = v.sc0;
      c1_data_in        = v.d1;
      c1_data_available = v.d1[0];
      c1_data_is_long   = v.d1[1];
      c1_hmac_reset     = v.d1[2];
      c1_start_continue = v.sc1;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      cmp({e.nm, ".gnt"},  32'(gnt),                 32'(e.e_gnt));
      cmp({e.nm, ".rst"},  32'(hmac_reset),          32'(e.e_rst));
      cmp({e.nm, ".data"}, 32'(hmac_data_in),        32'(e.e_data));
      cmp({e.nm, ".dav"},  32'(hmac_data_available), 32'(e.e_data[0]));
      cmp({e.nm, ".dil"},  32'(hmac_data_is_long),   32'(e.e_data[1]));
      cmp({e.nm, ".sc"},   32'(hmac_start_continue), 32'(e.e_sc));
      cmp({e.nm, ".cbsy"}, 32'(c_busy),              32'(e.e_cb));
      cmp({e.nm, ".abrt"}, 32'(aborted),             32'(e.e_ab));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req = '0; hmac_busy = 1'b0;
      c0_hmac_reset = 0; c0_start_continue = 0;
      c0_data_available = 0; c0_data_is_long = 0; c0_data_in = '0;
      c1_hmac_reset = 0; c1_start_continue = 0;
      c1_data_available = 0; c1_data_is_long = 0; c1_data_in = '0;

      // Columns: req busy d0 d1 sc0 sc1 | gnt rst data sc c_busy aborted
      tbl.push_back(mk("idle0",  2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("scrub0", 2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("own0",   2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b01,0,16'hA5A5,0,2'b10,2'b00));
      tbl.push_back(mk("iso",    2'b11,0,16'hA5A5,16'hFFFF,0,1, 2'b01,0,16'hA5A5,0,2'b10,2'b00));
      tbl.push_back(mk("pass0",  2'b11,1,16'h1234,16'hFFFF,1,1, 2'b01,0,16'h1234,1,2'b11,2'b00));
      tbl.push_back(mk("drop0",  2'b10,0,16'h1234,16'hBEEF,0,0, 2'b01,0,16'h1234,0,2'b10,2'b00));
      tbl.push_back(mk("drain0", 2'b10,0,16'h1234,16'hBEEF,0,0, 2'b00,0,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("idle1",  2'b10,0,16'h1234,16'hBEEF,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("scrub1", 2'b10,0,16'h1234,16'hBEEF,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("own1",   2'b10,0,16'h1234,16'hBEEF,0,0, 2'b10,1,16'hBEEF,0,2'b01,2'b00));
      tbl.push_back(mk("own1b",  2'b11,1,16'h1234,16'hBEEF,1,0, 2'b10,1,16'hBEEF,0,2'b11,2'b00));
      tbl.push_back(mk("drop1",  2'b01,1,16'h1234,16'hBEEF,0,1, 2'b10,1,16'hBEEF,1,2'b11,2'b00));
      for (int i = 0; i < 20; i++)
         tbl.push_back(mk("drain1", 2'b01,1,16'h1234,16'hBEEF,0,0, 2'b00,0,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("drainend",2'b01,0,16'h1234,16'hBEEF,0,0, 2'b00,0,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("idle2",  2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("scrubbz",2'b01,1,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      tbl.push_back(mk("scrub2", 2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));

      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp("rst.gnt",  32'(gnt),        32'h0);
      cmp("rst.hrst", 32'(hmac_reset), 32'h1);
      cmp("rst.cbsy", 32'(c_busy),     32'h3);
      cmp("rst.abrt", 32'(aborted),    32'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) apply(tbl[i]);

      // Watchdog: restart at owned cycle 4, then 8 idle cycles to revoke
      for (int i = 0; i < 13; i++)
         apply(mk("wd", 2'b01,0,16'hA5A5,16'h5A5A,(i == 4),0,
                  2'b01,0,16'hA5A5,(i == 4),2'b10,2'b00));
      apply(mk("abort",  2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b01));
      for (int i = 0; i < 3; i++)
         apply(mk("abhold",2'b01,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("abrel",  2'b00,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("idle3",  2'b11,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("scrub3", 2'b11,0,16'hA5A5,16'h5A5A,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("own3",   2'b11,1,16'h1234,16'h5A5A,0,0, 2'b10,0,16'h5A5A,0,2'b11,2'b00));

      // Asynchronous reset in the middle of an owned, busy cycle
      #2;
      req = 2'b00;
      reset = 1'b1;
      #1;
      cmp("arst.gnt",  32'(gnt),        32'h0);
      cmp("arst.hrst", 32'(hmac_reset), 32'h1);
      cmp("arst.cbsy", 32'(c_busy),     32'h3);
      cmp("arst.data", 32'(hmac_data_in), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      hmac_busy = 1'b0;
      @(posedge clk);
      #1;
      apply(mk("rsidle", 2'b10,0,16'h1234,16'hBEEF,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("rsscrb", 2'b10,0,16'h1234,16'hBEEF,0,0, 2'b00,1,16'h0,0,2'b11,2'b00));
      apply(mk("rsown",  2'b10,0,16'h1234,16'hBEEF,0,0, 2'b10,1,16'hBEEF,0,2'b01,2'b00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
